// File: rtl/wb_regfile.sv
// Writeback select plus 2^AW x DW register file (R0 hardwired to zero), commit record and retire counter.
// Optional write-through read bypass enabled by defining WB_BYPASS_EN.
module wb_regfile #(
  parameter int DW = 8,
  parameter int AW = 3,
  parameter int CW = 16
) (
  input  logic          clk2,
  input  logic          reset,
  input  logic [DW-1:0] alu_in,
  input  logic [DW-1:0] mem_in,
  input  logic          MemToRegmux,
  input  logic          RegWrite,
  input  logic [AW-1:0] regwradd,
  input  logic [AW-1:0] rs1_add,
  input  logic [AW-1:0] rs2_add,
  output logic [DW-1:0] rs1_data,
  output logic [DW-1:0] rs2_data,
  output logic [DW-1:0] wb_data,
  output logic          wb_valid_q,
  output logic [AW-1:0] wb_add_q,
  output logic [DW-1:0] wb_data_q,
  output logic [CW-1:0] retire_cnt
);
  localparam int NREG = 1 << AW;

  logic [DW-1:0] regs [NREG];
  logic          commit_p0;
  logic          vld_p1;
  logic [AW-1:0] add_p1;
  logic [DW-1:0] data_p1;
  logic [CW-1:0] cnt_p1;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == '1) ? v : v + CW'(1);
  endfunction

  assign wb_data   = MemToRegmux ? mem_in : alu_in;
  assign commit_p0 = RegWrite && (regwradd != '0) && !reset;

  always_comb begin
    rs1_data = (rs1_add == '0) ? '0 : regs[rs1_add];
    rs2_data = (rs2_add == '0) ? '0 : regs[rs2_add];
`ifdef WB_BYPASS_EN
    if (commit_p0 && (rs1_add == regwradd)) rs1_data = wb_data;
    if (commit_p0 && (rs2_add == regwradd)) rs2_data = wb_data;
`endif
  end

  // p0 -> p1: register file write, commit record, retire counter
  always_ff @(posedge clk2) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
      vld_p1  <= 1'b0;
      add_p1  <= '0;
      data_p1 <= '0;
      cnt_p1  <= '0;
    end else begin
      vld_p1 <= commit_p0;
      if (commit_p0) begin
        regs[regwradd] <= wb_data;
        add_p1         <= regwradd;
        data_p1        <= wb_data;
        cnt_p1         <= sat_inc(cnt_p1);
      end
    end
  end

  assign wb_valid_q = vld_p1;
  assign wb_add_q   = add_p1;
  assign wb_data_q  = data_p1;
  assign retire_cnt = cnt_p1;
endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile (CW=4 so counter saturation is reachable) against an array-based model.
module tb_wb_regfile;
  logic       clk2 = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] alu_in = '0, mem_in = '0;
  logic       MemToRegmux = 1'b0, RegWrite = 1'b0;
  logic [2:0] regwradd = '0, rs1_add = '0, rs2_add = '0;
  logic [7:0] rs1_data, rs2_data, wb_data, wb_data_q;
  logic       wb_valid_q;
  logic [2:0] wb_add_q;
  logic [3:0] retire_cnt;

  int checks = 0;
  int failures = 0;

  // reference state
  logic [7:0] m_r [8];
  int         m_cnt;
  logic       m_vld;
  logic [2:0] m_add;
  logic [7:0] m_data;
  bit         m_init = 0;

  wb_regfile #(.DW(8), .AW(3), .CW(4)) dut (
    .clk2(clk2), .reset(reset), .alu_in(alu_in), .mem_in(mem_in),
    .MemToRegmux(MemToRegmux), .RegWrite(RegWrite), .regwradd(regwradd),
    .rs1_add(rs1_add), .rs2_add(rs2_add), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .wb_data(wb_data), .wb_valid_q(wb_valid_q), .wb_add_q(wb_add_q),
    .wb_data_q(wb_data_q), .retire_cnt(retire_cnt)
  );

  always #5 clk2 = ~clk2;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_wb();
    return MemToRegmux ? mem_in : alu_in;
  endfunction

  function automatic bit exp_commit();
    return RegWrite && (regwradd != 0) && !reset;
  endfunction

  function automatic logic [7:0] exp_rd(input logic [2:0] a);
    if (a == 0) return 8'h00;
`ifdef WB_BYPASS_EN
    if (exp_commit() && a == regwradd) return exp_wb();
`endif
    return m_r[a];
  endfunction

  task automatic check_reads(input string tag);
    chk({tag, ".wb_data"}, wb_data, exp_wb());
    if (m_init) begin
      chk({tag, ".rs1"}, rs1_data, exp_rd(rs1_add));
      chk({tag, ".rs2"}, rs2_data, exp_rd(rs2_add));
    end
  endtask

  // Apply inputs, check combinational outputs before the edge, clock, update model, check after the edge.
  task automatic step(input string tag, input logic r, input logic we, input logic m,
                      input logic [2:0] wa, input logic [2:0] r1, input logic [2:0] r2,
                      input logic [7:0] a, input logic [7:0] md);
    bit c;
    logic [7:0] v;
    reset = r; RegWrite = we; MemToRegmux = m; regwradd = wa;
    rs1_add = r1; rs2_add = r2; alu_in = a; mem_in = md;
    #1;
    check_reads({tag, ".pre"});
    c = exp_commit();
    v = exp_wb();
    @(posedge clk2);
    if (r) begin
      for (int i = 0; i < 8; i++) m_r[i] = 8'h00;
      m_cnt = 0; m_vld = 0; m_add = 0; m_data = 0; m_init = 1;
    end else begin
      m_vld = c;
      if (c) begin
        m_r[wa] = v; m_add = wa; m_data = v;
        if (m_cnt < 15) m_cnt++;
      end
    end
    #1;
    chk({tag, ".vld_q"}, wb_valid_q, m_vld);
    chk({tag, ".add_q"}, wb_add_q, m_add);
    chk({tag, ".data_q"}, wb_data_q, m_data);
    chk({tag, ".cnt"}, retire_cnt, m_cnt);
    check_reads({tag, ".post"});
  endtask

  initial begin
    @(posedge clk2); #1;
    step("rst0", 1, 0, 0, 0, 0, 0, 8'h00, 8'h00);
    step("rst1", 1, 0, 0, 0, 1, 2, 8'h00, 8'h00);
    for (int i = 0; i < 8; i++) begin
      step("rdall", 0, 0, 0, 0, 3'(i), 3'(7 - i), 8'h12, 8'h34);
      chk("rdall.zero", rs1_data, 8'h00);
    end
    step("wr_alu", 0, 1, 0, 3, 3, 0, 8'h5A, 8'hA5);
    chk("wr_alu.r3", rs1_data, 8'h5A);
    chk("wr_alu.cnt1", retire_cnt, 4'd1);
    step("wr_mem", 0, 1, 1, 3, 3, 3, 8'h5A, 8'hA5);
    chk("wr_mem.r3", rs2_data, 8'hA5);
    chk("wr_mem.cnt2", retire_cnt, 4'd2);
    step("wr_r0", 0, 1, 0, 0, 0, 0, 8'hFF, 8'hFF);
    chk("wr_r0.vld", wb_valid_q, 1'b0);
    chk("wr_r0.cnt", retire_cnt, 4'd2);
    step("r5_old", 0, 1, 0, 5, 0, 0, 8'h11, 8'h00);
    reset = 0; RegWrite = 1; MemToRegmux = 0; regwradd = 5; rs1_add = 5; alu_in = 8'h3C; #1;
`ifdef WB_BYPASS_EN
    chk("byp.pre", rs1_data, 8'h3C);
`else
    chk("nobyp.pre", rs1_data, 8'h11);
`endif
    step("r5_new", 0, 1, 0, 5, 5, 5, 8'h3C, 8'h00);
    RegWrite = 0; #1;
    chk("r5.post", rs1_data, 8'h3C);
    step("rst_wr", 1, 1, 0, 2, 2, 5, 8'h77, 8'h00);
    chk("rst_wr.r2", rs1_data, 8'h00);
    chk("rst_wr.cnt", retire_cnt, 4'd0);
    for (int i = 0; i < 17; i++) begin
      step("sat", 0, 1, i[0], 3'((i % 7) + 1), 3'(i), 3'(i + 3), 8'($urandom), 8'($urandom));
      chk("sat.cnt", retire_cnt, (i < 15) ? 4'(i + 1) : 4'd15);
    end
    step("rst2", 1, 0, 0, 0, 0, 0, 8'h00, 8'h00);
    for (int i = 0; i < 300; i++) begin
      step("rand", ($urandom_range(0, 39) == 0), 1'($urandom), 1'($urandom),
           3'($urandom), 3'($urandom), 3'($urandom), 8'($urandom), 8'($urandom));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
